// File: rtl/pbs_pkg.sv
// Shared types and constants for the pbs turn sequencer.
// Optional idle auto-move is enabled by defining PBS_TURN_TIMEOUT_EN.
package pbs_pkg;

    localparam int unsigned HP_W   = 5;
    localparam int unsigned MOVE_W = 2;

    localparam logic ACT_PLAYER = 1'b0;
    localparam logic ACT_AI     = 1'b1;
    localparam logic TGT_PLAYER = 1'b0;
    localparam logic TGT_AI     = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        P_SETTLE,
        P_APPLY,
        P_CHECK,
        AI_ROLL,
        AI_SETTLE,
        AI_APPLY,
        AI_CHECK,
        OVER
    } state_e;

    // Bits needed to hold a down-count that starts at max_val-1.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/pbs_edge_det.sv
// Synchronous rising-edge detector; rise_o is high in the cycle d_i first reads 1.
module pbs_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/pbs_turn_ctrl.sv
// Turn sequencer driving the pbs_dp battle datapath: player attack, win check, AI attack, loss check.
// Define PBS_TURN_TIMEOUT_EN to auto-start a turn with move 0 after TIMEOUT_CYCLES idle cycles.
module pbs_turn_ctrl #(
    parameter int unsigned HP_W           = 5,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned ROLL_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  logic [1:0]      p_move_sel,
    input  logic [HP_W-1:0] p_hp,
    input  logic [HP_W-1:0] AI_hp,
    output logic [1:0]      p_move,
    output logic            actr,
    output logic            target,
    output logic            app_dmg,
    output logic            stop,
    output logic            busy,
    output logic            p_win,
    output logic            ai_win,
    output logic [4:0]      turn_cnt
);

    import pbs_pkg::*;

    localparam int unsigned SR_MAX = (SETTLE_CYCLES > ROLL_CYCLES) ? SETTLE_CYCLES : ROLL_CYCLES;
`ifdef PBS_TURN_TIMEOUT_EN
    localparam int unsigned WAIT_MAX = (TIMEOUT_CYCLES > SR_MAX) ? TIMEOUT_CYCLES : SR_MAX;
`else
    localparam int unsigned WAIT_MAX = SR_MAX;
`endif
    localparam int unsigned CNT_W = cnt_width(WAIT_MAX);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ROLL_LOAD   = CNT_W'(ROLL_CYCLES - 1);
`ifdef PBS_TURN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] IDLE_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);
`else
    localparam logic [CNT_W-1:0] IDLE_LOAD   = '0;
`endif

    if (SETTLE_CYCLES < 2 || ROLL_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("pbs_turn_ctrl: SETTLE_CYCLES must be >= 2, ROLL/TIMEOUT_CYCLES >= 1");
    end

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [MOVE_W-1:0]  p_move_q;
    logic               actr_q;
    logic               target_q;
    logic               app_dmg_q;
    logic               stop_q;
    logic               busy_q;
    logic               p_win_q;
    logic               ai_win_q;
    logic [4:0]         turn_cnt_q;
    logic               go_rise;
    logic               start;
    logic [MOVE_W-1:0]  start_move;

    pbs_edge_det u_go_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (go),
        .rise_o (go_rise)
    );

    // A real go edge always wins over an expiring idle timeout.
    always_comb begin
        start      = go_rise;
        start_move = p_move_sel;
`ifdef PBS_TURN_TIMEOUT_EN
        if (!go_rise && cnt_q == '0) begin
            start      = 1'b1;
            start_move = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= IDLE_LOAD;
            p_move_q   <= '0;
            actr_q     <= ACT_PLAYER;
            target_q   <= TGT_PLAYER;
            app_dmg_q  <= 1'b0;
            stop_q     <= 1'b1;
            busy_q     <= 1'b0;
            p_win_q    <= 1'b0;
            ai_win_q   <= 1'b0;
            turn_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && state_q == IDLE) begin
                        p_move_q <= start_move;
                        actr_q   <= ACT_PLAYER;
                        target_q <= TGT_AI;
                        busy_q   <= 1'b1;
                        cnt_q    <= SETTLE_LOAD;
                        state_q  <= P_SETTLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                P_SETTLE: begin
                    if (cnt_q == '0) begin
                        app_dmg_q <= 1'b1;
                        state_q   <= P_APPLY;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                P_APPLY: begin
                    app_dmg_q <= 1'b0;
                    state_q   <= P_CHECK;
                end
                P_CHECK: begin
                    if (AI_hp == '0) begin
                        p_win_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= OVER;
                    end else begin
                        stop_q  <= 1'b0;
                        cnt_q   <= ROLL_LOAD;
                        state_q <= AI_ROLL;
                    end
                end
                AI_ROLL: begin
                    if (cnt_q == '0) begin
                        stop_q   <= 1'b1;
                        actr_q   <= ACT_AI;
                        target_q <= TGT_PLAYER;
                        cnt_q    <= SETTLE_LOAD;
                        state_q  <= AI_SETTLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                AI_SETTLE: begin
                    if (cnt_q == '0) begin
                        app_dmg_q <= 1'b1;
                        state_q   <= AI_APPLY;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                AI_APPLY: begin
                    app_dmg_q <= 1'b0;
                    state_q   <= AI_CHECK;
                end
                AI_CHECK: begin
                    busy_q <= 1'b0;
                    if (p_hp == '0) begin
                        ai_win_q <= 1'b1;
                        state_q  <= OVER;
                    end else begin
                        if (turn_cnt_q != 5'd31) begin
                            turn_cnt_q <= turn_cnt_q + 5'd1;
                        end
                        actr_q  <= ACT_PLAYER;
                        cnt_q   <= IDLE_LOAD;
                        state_q <= IDLE;
                    end
                end
                OVER: begin
                    app_dmg_q <= 1'b0;
                    stop_q    <= 1'b1;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign p_move   = p_move_q;
    assign actr     = actr_q;
    assign target   = target_q;
    assign app_dmg  = app_dmg_q;
    assign stop     = stop_q;
    assign busy     = busy_q;
    assign p_win    = p_win_q;
    assign ai_win   = ai_win_q;
    assign turn_cnt = turn_cnt_q;

endmodule

// File: tb/tb_pbs_turn_ctrl.sv
// Randomized self-checking bench for pbs_turn_ctrl against a cycle-offset turn model.
// Build with PBS_TURN_TIMEOUT_EN to exercise the idle auto-move instead of the turn sequences.
module tb_pbs_turn_ctrl;

    localparam int unsigned S = 2;
    localparam int unsigned R = 4;
`ifdef PBS_TURN_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 1000000;
`endif
    localparam int K_APPLY1 = S + 1;
    localparam int K_PCHK   = S + 3;
    localparam int K_AISW   = S + R + 3;
    localparam int K_APPLY2 = 2 * S + R + 3;
    localparam int K_DONE   = 2 * S + R + 5;

    logic       clk;
    logic       rst;
    logic       go;
    logic [1:0] p_move_sel;
    logic [4:0] p_hp;
    logic [4:0] AI_hp;
    logic [1:0] p_move;
    logic       actr;
    logic       target;
    logic       app_dmg;
    logic       stop;
    logic       busy;
    logic       p_win;
    logic       ai_win;
    logic [4:0] turn_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    int       m_turns;
    logic [1:0] m_move;
    bit       m_over;
    bit       m_actr;
    bit       m_target;
    bit       m_pwin;
    bit       m_aiwin;

    pbs_turn_ctrl #(
        .HP_W           (5),
        .SETTLE_CYCLES  (S),
        .ROLL_CYCLES    (R),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .p_move_sel (p_move_sel),
        .p_hp       (p_hp),
        .AI_hp      (AI_hp),
        .p_move     (p_move),
        .actr       (actr),
        .target     (target),
        .app_dmg    (app_dmg),
        .stop       (stop),
        .busy       (busy),
        .p_win      (p_win),
        .ai_win     (ai_win),
        .turn_cnt   (turn_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_seq();
        rst = 1'b0;
        go  = 1'b0;
        tick();
        chk("rst_p_move", p_move, 0);
        chk("rst_actr", actr, 0);
        chk("rst_target", target, 0);
        chk("rst_app_dmg", app_dmg, 0);
        chk("rst_stop", stop, 1);
        chk("rst_busy", busy, 0);
        chk("rst_p_win", p_win, 0);
        chk("rst_ai_win", ai_win, 0);
        chk("rst_turn_cnt", turn_cnt, 0);
        m_turns = 0; m_move = 2'd0; m_over = 0;
        m_actr = 0; m_target = 0; m_pwin = 0; m_aiwin = 0;
        rst = 1'b1;
    endtask

    // One go pulse (or held go) and cycle-by-cycle comparison at offset k after the go edge.
    task automatic run_turn(input logic [1:0] sel, input logic [4:0] aihp, input logic [4:0] php,
                            input bit hold, input int abort_at);
        bit aidead;
        int kend;
        int sat_next;
        aidead   = (aihp == 0);
        kend     = aidead ? K_PCHK : K_DONE;
        sat_next = (m_turns >= 31) ? 31 : m_turns + 1;
        chk("pre_busy", busy, 0);
        p_move_sel = sel;
        AI_hp      = aihp;
        p_hp       = php;
        go         = 1'b1;
        for (int k = 1; k <= K_DONE + 1; k++) begin
            if (k == abort_at) begin
                rst = 1'b0;
                return;
            end
            tick();
            if (!hold) go = 1'b0;
            chk($sformatf("busy@k%0d", k), busy, k < kend);
            chk($sformatf("app_dmg@k%0d", k), app_dmg,
                (k == K_APPLY1) || (!aidead && k == K_APPLY2));
            chk($sformatf("stop@k%0d", k), stop, !(!aidead && k >= K_PCHK && k < K_AISW));
            chk($sformatf("actr@k%0d", k), actr,
                !aidead && k >= K_AISW && (k < K_DONE || php == 0));
            chk($sformatf("target@k%0d", k), target, aidead || k < K_AISW);
            chk($sformatf("p_move@k%0d", k), p_move, sel);
            chk($sformatf("p_win@k%0d", k), p_win, aidead && k >= K_PCHK);
            chk($sformatf("ai_win@k%0d", k), ai_win, !aidead && php == 0 && k >= K_DONE);
            chk($sformatf("turn_cnt@k%0d", k), turn_cnt,
                (!aidead && php != 0 && k >= K_DONE) ? sat_next : m_turns);
        end
        m_move = sel;
        if (aidead) begin
            m_over = 1; m_pwin = 1; m_actr = 0; m_target = 1;
        end else if (php == 0) begin
            m_over = 1; m_aiwin = 1; m_actr = 1; m_target = 0;
        end else begin
            m_turns = sat_next; m_actr = 0; m_target = 0;
        end
        if (hold) begin
            for (int i = 0; i < 100 - (K_DONE + 1); i++) begin
                tick();
                chk("hold_busy", busy, 0);
                chk("hold_turn_cnt", turn_cnt, m_turns);
            end
            go = 1'b0;
            tick();
        end
    endtask

    // After game over a go pulse must change nothing.
    task automatic dead_go();
        p_move_sel = ~m_move;
        go = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            go = 1'b0;
            chk("over_busy", busy, 0);
            chk("over_app_dmg", app_dmg, 0);
            chk("over_stop", stop, 1);
            chk("over_p_move", p_move, m_move);
            chk("over_actr", actr, m_actr);
            chk("over_target", target, m_target);
            chk("over_p_win", p_win, m_pwin);
            chk("over_ai_win", ai_win, m_aiwin);
        end
    endtask

    initial begin
        rst = 1'b0; go = 1'b0; p_move_sel = 2'd0; p_hp = 5'd15; AI_hp = 5'd15;
        reset_seq();
`ifdef PBS_TURN_TIMEOUT_EN
        p_move_sel = 2'd3;
        for (int i = 1; i < int'(TMO); i++) begin
            tick();
            chk("tmo_wait_busy", busy, 0);
        end
        tick();
        chk("tmo_busy", busy, 1);
        chk("tmo_p_move", p_move, 0);
        chk("tmo_target", target, 1);
        chk("tmo_actr", actr, 0);
`else
        run_turn(2'd2, 5'd15, 5'd15, 0, 0);
        run_turn(2'd1, 5'd0, 5'd15, 0, 0);
        dead_go();
        reset_seq();
        run_turn(2'd3, 5'd15, 5'd0, 0, 0);
        dead_go();
        reset_seq();
        run_turn(2'd2, 5'd9, 5'd9, 1, 0);
        run_turn(2'd1, 5'd7, 5'd7, 0, 10);
        reset_seq();
        for (int t = 0; t < 33; t++) begin
            run_turn(2'($urandom_range(0, 3)), 5'($urandom_range(1, 31)),
                     5'($urandom_range(1, 31)), 0, 0);
        end
        for (int t = 0; t < 20; t++) begin
            logic [4:0] a;
            logic [4:0] p;
            a = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            p = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            run_turn(2'($urandom_range(0, 3)), a, p, 0, 0);
            if (m_over) begin
                dead_go();
                reset_seq();
            end
        end
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
